// File: rtl/perf_counter_dump_pkg.sv
// perf_counter_dump_pkg
// Shared constants, state encoding and the byte-select helper for the
// performance-counter dump block.
// Frame layout: HDR_BYTE, NUM_CNT, then NUM_CNT counters LSB first, then an
// XOR checksum of every preceding byte.
package perf_counter_dump_pkg;

    localparam int NUM_CNT = 5;
    localparam int CNT_W = 32;
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    localparam int DATA_BYTES = NUM_CNT * CNT_W / 8;
    localparam int SNAP_W = NUM_CNT * CNT_W;
    localparam int IDX_W = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);
    localparam logic [7:0] COUNT_BYTE = 8'(NUM_CNT);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        CNT  = 3'd2,
        DATA = 3'd3,
        CHK  = 3'd4,
        DONE = 3'd5
    } state_t;

    // Byte idx of the flattened snapshot; byte 0 is the LSB of the first counter.
    function automatic logic [7:0] selectByte(input logic [SNAP_W-1:0] snap,
                                              input logic [IDX_W-1:0] idx);
        logic [7:0] result;
        result = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (idx == IDX_W'(i)) begin
                result = snap[i*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/perf_counter_dump.sv
// perf_counter_dump
// Takes an atomic snapshot of the five performance counters on dump_req and
// streams it out as a framed byte sequence over a valid/ready interface.
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   dump_req           - start a snapshot/frame (only honoured in IDLE)
//   cycle_count .. branch_mispredicts - live 32-bit counter values
//   tx_data, tx_valid  - current frame byte and its valid flag
//   tx_ready           - sink accepts the byte when tx_valid && tx_ready
//   busy               - high in every state except IDLE
//   dump_done          - one-cycle pulse after the checksum byte is accepted
module perf_counter_dump
    import perf_counter_dump_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        dump_req,
    input  logic [31:0] cycle_count,
    input  logic [31:0] instruction_count,
    input  logic [31:0] stall_count,
    input  logic [31:0] branch_count,
    input  logic [31:0] branch_mispredicts,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        dump_done
);

    state_t             state_q;
    logic [IDX_W-1:0]   byteIdx_q;
    logic [7:0]         checksum_q;
    logic [SNAP_W-1:0]  snap_q;
    logic [7:0]         txData_q;
    logic               txValid_q;
    logic               busy_q;
    logic               dumpDone_q;

    logic               accept;
    logic [7:0]         checksum_d;
    logic [IDX_W-1:0]   byteIdx_d;
    logic [7:0]         nextData_d;

    assign accept     = txValid_q && tx_ready;
    assign checksum_d = checksum_q ^ txData_q;
    assign byteIdx_d  = byteIdx_q + 1'b1;
    assign nextData_d = selectByte(snap_q, byteIdx_d);

    // Frame sequencer. All outputs are registered, so each transition loads
    // the byte that the next state will present.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            byteIdx_q  <= '0;
            checksum_q <= '0;
            snap_q     <= '0;
            txData_q   <= '0;
            txValid_q  <= 1'b0;
            busy_q     <= 1'b0;
            dumpDone_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dumpDone_q <= 1'b0;
                    if (dump_req) begin
                        // First counter sits in the low bits so byte 0 is its LSB.
                        snap_q     <= {branch_mispredicts, branch_count, stall_count,
                                       instruction_count, cycle_count};
                        checksum_q <= '0;
                        byteIdx_q  <= '0;
                        txData_q   <= HDR_BYTE;
                        txValid_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= HDR;
                    end
                end
                HDR: begin
                    if (accept) begin
                        checksum_q <= checksum_d;
                        txData_q   <= COUNT_BYTE;
                        state_q    <= CNT;
                    end
                end
                CNT: begin
                    if (accept) begin
                        checksum_q <= checksum_d;
                        byteIdx_q  <= '0;
                        txData_q   <= selectByte(snap_q, '0);
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        checksum_q <= checksum_d;
                        if (byteIdx_q == LAST_IDX) begin
                            // Checksum byte already includes the data byte being accepted now.
                            txData_q <= checksum_d;
                            state_q  <= CHK;
                        end else begin
                            byteIdx_q <= byteIdx_d;
                            txData_q  <= nextData_d;
                        end
                    end
                end
                CHK: begin
                    if (accept) begin
                        checksum_q <= checksum_d;
                        txData_q   <= '0;
                        txValid_q  <= 1'b0;
                        dumpDone_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    dumpDone_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    txData_q   <= '0;
                    txValid_q  <= 1'b0;
                    busy_q     <= 1'b0;
                    dumpDone_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign tx_data   = txData_q;
    assign tx_valid  = txValid_q;
    assign busy      = busy_q;
    assign dump_done = dumpDone_q;

endmodule

// File: tb/tb_perf_counter_dump.sv
// tb_perf_counter_dump
// Scoreboard bench for perf_counter_dump: stimulus pushes the expected frame
// bytes into a queue, and a negedge monitor pops and compares on every handshake.
module tb_perf_counter_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        dump_req;
    logic        tx_ready;
    logic [31:0] cycle_count;
    logic [31:0] instruction_count;
    logic [31:0] stall_count;
    logic [31:0] branch_count;
    logic [31:0] branch_mispredicts;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        dump_done;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t expQ[$];
    exp_t mon;
    bit   expectDone = 1'b0;
    int   testsRun = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    perf_counter_dump dut (
        .clk                (clk),
        .reset              (reset),
        .dump_req           (dump_req),
        .cycle_count        (cycle_count),
        .instruction_count  (instruction_count),
        .stall_count        (stall_count),
        .branch_count       (branch_count),
        .branch_mispredicts (branch_mispredicts),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .busy               (busy),
        .dump_done          (dump_done)
    );

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushByte(input logic [7:0] b, input logic last);
        exp_t e;
        e.b = b;
        e.last = last;
        expQ.push_back(e);
    endtask

    // Reference frame: header, count, counters LSB first, running XOR checksum.
    task automatic pushFrame(input logic [31:0] c0, input logic [31:0] c1,
                             input logic [31:0] c2, input logic [31:0] c3,
                             input logic [31:0] c4);
        logic [31:0] cnt [5];
        logic [7:0]  x;
        logic [7:0]  b;
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3; cnt[4] = c4;
        pushByte(8'hA5, 1'b0);
        pushByte(8'h05, 1'b0);
        x = 8'hA5 ^ 8'h05;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) begin
                b = cnt[i][8*j +: 8];
                pushByte(b, 1'b0);
                x = x ^ b;
            end
        end
        pushByte(x, 1'b1);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDone(output bit ok);
        ok = 1'b0;
        for (int cyc = 0; cyc < 100 && !ok; cyc++) begin
            stepCycle();
            if (dump_done) ok = 1'b1;
        end
    endtask

    // mode 0: ready high; 1: counters move after the request; 2: ready stalls
    // mid-DATA; 3: extra dump_req while byte 7 is presented.
    task automatic applyStimulus(input logic [31:0] c0, input logic [31:0] c1,
                                 input logic [31:0] c2, input logic [31:0] c3,
                                 input logic [31:0] c4, input int mode);
        int         accepted;
        int         stallIdx;
        bit         done;
        logic [8:0] pat;
        pat = 9'b000001001;
        accepted = 0;
        stallIdx = 0;
        done = 1'b0;
        cycle_count = c0;
        instruction_count = c1;
        stall_count = c2;
        branch_count = c3;
        branch_mispredicts = c4;
        tx_ready = 1'b1;
        dump_req = 1'b1;
        stepCycle();
        dump_req = 1'b0;
        checkOutput("valid_after_req", 32'(tx_valid), 32'd1);
        checkOutput("busy_after_req", 32'(busy), 32'd1);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (mode == 1) begin
                cycle_count++;
                instruction_count++;
                stall_count++;
                branch_count++;
                branch_mispredicts++;
            end
            if (mode == 2 && accepted >= 8 && stallIdx < 9) begin
                tx_ready = pat[stallIdx];
                stallIdx++;
            end else begin
                tx_ready = 1'b1;
            end
            dump_req = (mode == 3 && accepted == 7);
            if (tx_valid && tx_ready) accepted++;
            stepCycle();
            if (dump_done) done = 1'b1;
        end
        dump_req = 1'b0;
        tx_ready = 1'b1;
        checkOutput("frame_completed", 32'(done), 32'd1);
        checkOutput("frame_len", 32'(accepted), 32'd23);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        stepCycle();
        checkOutput("idle_after_frame", 32'(busy), 32'd0);
    endtask

    // Monitor: compares dump_done timing, every accepted byte, and stalled bytes.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                expectDone = 1'b0;
            end else begin
                if (expectDone || dump_done) begin
                    checkOutput("dump_done", 32'(dump_done), 32'(expectDone));
                    if (expectDone) checkOutput("valid_in_done", 32'(tx_valid), 32'd0);
                    expectDone = 1'b0;
                end
                if (tx_valid) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_byte", 32'(tx_valid), 32'd0);
                    end else if (tx_ready) begin
                        mon = expQ.pop_front();
                        checkOutput("frame_byte", 32'(tx_data), 32'(mon.b));
                        if (mon.last) expectDone = 1'b1;
                    end else begin
                        checkOutput("stall_hold", 32'(tx_data), 32'(expQ[0].b));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] vec1 [23];
        bit         ok;
        int         accepted;

        reset = 1'b1;
        dump_req = 1'b0;
        tx_ready = 1'b0;
        cycle_count = '0;
        instruction_count = '0;
        stall_count = '0;
        branch_count = '0;
        branch_mispredicts = '0;
        repeat (3) stepCycle();
        checkOutput("reset_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("reset_tx_data", 32'(tx_data), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_dump_done", 32'(dump_done), 32'd0);
        reset = 1'b0;
        tx_ready = 1'b1;
        repeat (2) stepCycle();
        checkOutput("idle_ready_valid", 32'(tx_valid), 32'd0);
        checkOutput("idle_ready_busy", 32'(busy), 32'd0);

        // Hand-computed reference frame.
        vec1 = '{8'hA5, 8'h05, 8'h10, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
                 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hBF};
        for (int i = 0; i < 23; i++) pushByte(vec1[i], (i == 22));
        applyStimulus(32'h10, 32'h0C, 32'h0, 32'h2, 32'h1, 0);

        // All ones: data bytes cancel, checksum is A5 ^ 05.
        pushByte(8'hA5, 1'b0);
        pushByte(8'h05, 1'b0);
        for (int i = 0; i < 20; i++) pushByte(8'hFF, 1'b0);
        pushByte(8'hA0, 1'b1);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);

        // Counters keep running after the request edge.
        pushFrame(32'h00001000, 32'h00000800, 32'h00000100, 32'h00000040, 32'h00000004);
        applyStimulus(32'h00001000, 32'h00000800, 32'h00000100, 32'h00000040, 32'h00000004, 1);

        // Back-pressure in the middle of the data bytes.
        pushFrame(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978, 32'h87654321);
        applyStimulus(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978, 32'h87654321, 2);

        // Request during byte 7 must not start another frame.
        pushFrame(32'hCAFEF00D, 32'h00C0FFEE, 32'h0, 32'hDEADBEEF, 32'h00000077);
        applyStimulus(32'hCAFEF00D, 32'h00C0FFEE, 32'h0, 32'hDEADBEEF, 32'h00000077, 3);
        repeat (3) stepCycle();
        checkOutput("ignored_req_busy", 32'(busy), 32'd0);
        checkOutput("ignored_req_valid", 32'(tx_valid), 32'd0);

        // dump_req held high: two frames separated by DONE and IDLE.
        pushFrame(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314);
        pushFrame(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314);
        cycle_count = 32'h01020304;
        instruction_count = 32'h05060708;
        stall_count = 32'h090A0B0C;
        branch_count = 32'h0D0E0F10;
        branch_mispredicts = 32'h11121314;
        tx_ready = 1'b1;
        dump_req = 1'b1;
        waitDone(ok);
        checkOutput("held_first_done", 32'(ok), 32'd1);
        checkOutput("held_gap_done_valid", 32'(tx_valid), 32'd0);
        stepCycle();
        checkOutput("held_gap_idle_valid", 32'(tx_valid), 32'd0);
        checkOutput("held_gap_idle_busy", 32'(busy), 32'd0);
        stepCycle();
        checkOutput("held_second_valid", 32'(tx_valid), 32'd1);
        checkOutput("held_second_hdr", 32'(tx_data), 32'hA5);
        dump_req = 1'b0;
        waitDone(ok);
        checkOutput("held_second_done", 32'(ok), 32'd1);
        checkOutput("held_queue_drained", 32'(expQ.size()), 32'd0);
        stepCycle();

        // Reset while byte 12 is presented aborts the frame.
        pushFrame(32'hAAAA5555, 32'h5555AAAA, 32'h33333333, 32'hCCCCCCCC, 32'h0000FFFF);
        cycle_count = 32'hAAAA5555;
        instruction_count = 32'h5555AAAA;
        stall_count = 32'h33333333;
        branch_count = 32'hCCCCCCCC;
        branch_mispredicts = 32'h0000FFFF;
        tx_ready = 1'b1;
        dump_req = 1'b1;
        stepCycle();
        dump_req = 1'b0;
        accepted = 0;
        for (int cyc = 0; cyc < 100 && accepted < 12; cyc++) begin
            if (tx_valid && tx_ready) accepted++;
            stepCycle();
        end
        checkOutput("abort_reached_byte12", 32'(accepted), 32'd12);
        reset = 1'b1;
        stepCycle();
        checkOutput("abort_valid", 32'(tx_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_data", 32'(tx_data), 32'd0);
        expQ.delete();
        reset = 1'b0;
        stepCycle();
        checkOutput("abort_idle_valid", 32'(tx_valid), 32'd0);

        pushFrame(32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005);
        applyStimulus(32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005, 0);

        repeat (2) stepCycle();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
